// File: rtl/binary_search_ctrl.sv
// ---------------------------------------------------------------------------
// binary_search_ctrl
//   Binary-search engine over an ascending-sorted, synchronous-read RAM.
//   A start pulse latches key/mode. The engine probes the RAM with a
//   half-open interval [lo,hi) and reports found/loc. mode=0 selects
//   exact match. mode=1 selects lower bound (first element >= key).
//
// Ports
//   clk       clock, all state on posedge
//   reset     asynchronous, active-high; clears all state
//   start     search request, sampled only in IDLE or DONE
//   key       search key, latched on accept
//   mode      0 = exact match, 1 = lower bound, latched on accept
//   mem_addr  RAM read address (RAM registers it, mem_q valid next cycle)
//   mem_q     RAM read data
//   busy      high while a search is in progress (PROBE/CMP)
//   done      high in DONE until the next accepted start or reset
//   found     result flag, valid while done
//   loc       result index or insertion point, valid while done (0..DEPTH)
//   probes    number of RAM probes used by the last search
// ---------------------------------------------------------------------------
module binary_search_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int SIGNED = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] key,
   input  logic              mode,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_q,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [ADDR_W:0]   loc,
   output logic [ADDR_W+1:0] probes
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PROBE,
      S_CMP,
      S_DONE
   } state_t;

   localparam logic [ADDR_W:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};
   // First probe of a fresh search is the middle of [0, DEPTH).
   localparam logic [ADDR_W-1:0] FIRST_MID = DEPTH_L[ADDR_W:1];

   state_t              state_q;
   logic [DATA_W-1:0]   key_q;
   logic                mode_q;
   logic [ADDR_W:0]     lo_q, hi_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                busy_q, done_q, found_q;
   logic [ADDR_W:0]     loc_q;
   logic [ADDR_W+1:0]   probes_q;

   // Next-interval datapath, used only when leaving CMP.
   logic [ADDR_W:0]     mid_cur;
   logic                key_eq, elem_lt;
   logic [ADDR_W:0]     lo_d, hi_d;
   logic [ADDR_W+1:0]   sum_d;
   logic [ADDR_W-1:0]   mid_d;
   logic                unused_sum_bits;

   // The address register still holds the mid being compared in CMP.
   assign mid_cur = {1'b0, mem_addr_q};

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      key_eq  = (mem_q == key_q);
      elem_lt = 1'b0;
      if (SIGNED != 0) elem_lt = ($signed(mem_q) < $signed(key_q));
      else             elem_lt = (mem_q < key_q);

      lo_d = lo_q;
      hi_d = hi_q;
      if (elem_lt) lo_d = mid_cur + 1'b1;
      else         hi_d = mid_cur;

      // Sum is one bit wider than lo/hi, so lo+hi cannot wrap.
      sum_d = {1'b0, lo_d} + {1'b0, hi_d};
      mid_d = sum_d[ADDR_W:1];
   end

   // The top sum bit is always zero (lo < hi <= DEPTH), and bit 0 is discarded by the halving.
   assign unused_sum_bits = sum_d[ADDR_W+1] ^ sum_d[0];

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         key_q      <= '0;
         mode_q     <= 1'b0;
         lo_q       <= '0;
         hi_q       <= '0;
         mem_addr_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         found_q    <= 1'b0;
         loc_q      <= '0;
         probes_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  key_q      <= key;
                  mode_q     <= mode;
                  lo_q       <= '0;
                  hi_q       <= DEPTH_L;
                  probes_q   <= '0;
                  done_q     <= 1'b0;
                  found_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  // Address is presented during PROBE, so it is loaded on entry.
                  mem_addr_q <= FIRST_MID;
                  state_q    <= S_PROBE;
               end
            end
            S_PROBE: begin
               probes_q <= probes_q + 1'b1;
               state_q  <= S_CMP;
            end
            S_CMP: begin
               if (!mode_q && key_eq) begin
                  found_q <= 1'b1;
                  loc_q   <= mid_cur;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end else if (lo_d == hi_d) begin
                  // Interval empty: lo is the insertion point / lower bound.
                  loc_q   <= lo_d;
                  found_q <= mode_q && (lo_d < DEPTH_L);
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end else begin
                  lo_q       <= lo_d;
                  hi_q       <= hi_d;
                  mem_addr_q <= mid_d;
                  state_q    <= S_PROBE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_addr = mem_addr_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign found    = found_q;
   assign loc      = loc_q;
   assign probes   = probes_q;

endmodule

// File: tb/tb_binary_search_ctrl.sv
// ---------------------------------------------------------------------------
// tb_binary_search_ctrl
//   Directed bench for binary_search_ctrl. The unsigned instance searches
//   RAM[i] = 8*i. The signed instance searches RAM[i] = 8*i - 128.
//   Both use DATA_W=8 and ADDR_W=5. Expected values are worked out by hand.
// ---------------------------------------------------------------------------
module tb_binary_search_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;

   // Unsigned instance.
   logic       start = 1'b0;
   logic [7:0] key = '0;
   logic       mode = 1'b0;
   logic [4:0] mem_addr;
   logic [7:0] mem_q;
   logic       busy, done, found;
   logic [5:0] loc;
   logic [6:0] probes;

   // Signed instance.
   logic       start1 = 1'b0;
   logic [7:0] key1 = '0;
   logic       mode1 = 1'b0;
   logic [4:0] mem_addr1;
   logic [7:0] mem_q1;
   logic       busy1, done1, found1;
   logic [5:0] loc1;
   logic [6:0] probes1;

   logic [7:0] ram0 [32];
   logic [7:0] ram1 [32];

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 32; i++) begin
         ram0[i] = 8'(8 * i);
         ram1[i] = 8'(8 * i - 128);
      end
   end

   // Synchronous-read RAM models: address registered, data valid next cycle.
   always @(posedge clk) begin
      mem_q  <= ram0[mem_addr];
      mem_q1 <= ram1[mem_addr1];
   end

   binary_search_ctrl #(.DATA_W(8), .ADDR_W(5), .SIGNED(0)) u_dut (
      .clk(clk), .reset(reset), .start(start), .key(key), .mode(mode),
      .mem_addr(mem_addr), .mem_q(mem_q), .busy(busy), .done(done),
      .found(found), .loc(loc), .probes(probes)
   );

   binary_search_ctrl #(.DATA_W(8), .ADDR_W(5), .SIGNED(1)) u_dut_s (
      .clk(clk), .reset(reset), .start(start1), .key(key1), .mode(mode1),
      .mem_addr(mem_addr1), .mem_q(mem_q1), .busy(busy1), .done(done1),
      .found(found1), .loc(loc1), .probes(probes1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
         $error("miscompare on %s", tag);
      end
   endtask

   // Pulse start for one accepting edge on the unsigned instance; returns #1 after that edge.
   task automatic launch(input logic [7:0] k, input logic m);
      @(negedge clk);
      key   = k;
      mode  = m;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges from the accepting edge until done; a timeout shows up as a latency miscompare.
   task automatic wait_done(input int exp_lat, input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_latency"}, n, exp_lat);
   endtask

   task automatic check_result(input string tag, input logic f, input int l, input int p);
      check({tag, "_found"},  32'(found),  32'(f));
      check({tag, "_loc"},    32'(loc),    l);
      check({tag, "_probes"}, 32'(probes), p);
      check({tag, "_busy"},   32'(busy),   0);
   endtask

   initial begin
      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",     32'(busy),     0);
      check("rst_done",     32'(done),     0);
      check("rst_found",    32'(found),    0);
      check("rst_loc",      32'(loc),      0);
      check("rst_probes",   32'(probes),   0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      @(negedge clk);
      reset = 1'b0;

      // Exact hit in the middle: 5 probes, done 10 cycles after accept.
      launch(8'd120, 1'b0);
      check("k120_accept_busy", 32'(busy), 1);
      check("k120_accept_done", 32'(done), 0);
      wait_done(10, "k120");
      check_result("k120", 1'b1, 15, 5);
      check("k120_addr_hold", 32'(mem_addr), 15);

      // Low boundary: 6 probes.
      launch(8'd0, 1'b0);
      wait_done(12, "k0");
      check_result("k0", 1'b1, 0, 6);

      // High boundary.
      launch(8'd248, 1'b0);
      wait_done(10, "k248");
      check_result("k248", 1'b1, 31, 5);

      // Exact miss: insertion point.
      launch(8'd60, 1'b0);
      wait_done(10, "k60");
      check_result("k60", 1'b0, 8, 5);

      // Lower bound beyond the last element: loc = DEPTH.
      launch(8'd255, 1'b1);
      wait_done(10, "lb255");
      check_result("lb255", 1'b0, 32, 5);

      // Lower bound between elements; result must hold while idle in DONE.
      launch(8'd61, 1'b1);
      wait_done(10, "lb61");
      check_result("lb61", 1'b1, 8, 5);
      repeat (3) @(posedge clk);
      #1;
      check("lb61_hold_done", 32'(done), 1);
      check("lb61_hold_loc",  32'(loc),  8);

      // Reset asserted during CMP aborts the search.
      launch(8'd120, 1'b0);
      @(posedge clk);
      #1;
      check("abort_in_cmp_busy", 32'(busy), 1);
      reset = 1'b1;
      #1;
      check("abort_busy",   32'(busy),   0);
      check("abort_done",   32'(done),   0);
      check("abort_found",  32'(found),  0);
      check("abort_loc",    32'(loc),    0);
      check("abort_probes", 32'(probes), 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("abort_idle_busy", 32'(busy), 0);
      check("abort_idle_done", 32'(done), 0);

      // Fresh search after reset.
      launch(8'd120, 1'b0);
      wait_done(10, "post_rst");
      check_result("post_rst", 1'b1, 15, 5);

      // Start held high through busy: key change after accept is ignored.
      @(negedge clk);
      key   = 8'd120;
      mode  = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      key = 8'd0;
      wait_done(10, "held");
      check_result("held", 1'b1, 15, 5);
      // Start still high in DONE relaunches with the current key.
      @(posedge clk);
      #1;
      start = 1'b0;
      check("relaunch_done", 32'(done), 0);
      check("relaunch_busy", 32'(busy), 1);
      wait_done(12, "relaunch");
      check_result("relaunch", 1'b1, 0, 6);

      // Signed compare: key -8 sits at index 15.
      @(negedge clk);
      key1   = 8'hF8;
      mode1  = 1'b0;
      start1 = 1'b1;
      @(posedge clk);
      #1;
      start1 = 1'b0;
      begin
         int n = 0;
         while (done1 !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
         end
         check("signed_latency", n, 10);
      end
      check("signed_found",  32'(found1),  1);
      check("signed_loc",    32'(loc1),    15);
      check("signed_probes", 32'(probes1), 5);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
